// File: rtl/alu_cond_stage.sv
// Execute/write-back stage behind the ALU. It holds the NZCV flag register,
// evaluates the condition code, and registers the op outcome into a valid/ready slot.
module alu_cond_stage #(
  parameter int Nbits   = 8,
  parameter int CntBits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Nbits-1:0]   alu_result,
  input  logic [3:0]         alu_nzcv,
  input  logic [3:0]         cond,
  input  logic [1:0]         flag_w,
  input  logic [3:0]         rd,
  input  logic               reg_w_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Nbits-1:0]   out_result,
  output logic [3:0]         out_rd,
  output logic               out_reg_w,
  output logic               out_cond_ex,
  output logic [3:0]         flags,
  output logic [CntBits-1:0] exec_cnt,
  output logic [CntBits-1:0] squash_cnt
);

  logic cond_ex;
  logic accept;
  logic fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Evaluated against the architectural flags, never the incoming ALU flags.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = !fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = !fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = !fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = !fv;
      4'b1000: cond_ex = fc && !fz;
      4'b1001: cond_ex = !fc || fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = !fz && (fn == fv);
      4'b1101: cond_ex = fz || (fn != fv);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_reg_w   <= 1'b0;
      out_cond_ex <= 1'b0;
      flags       <= '0;
      exec_cnt    <= '0;
      squash_cnt  <= '0;
    end else if (accept) begin
      // Squashed ops still occupy the slot so downstream ordering is kept.
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_rd      <= rd;
      out_reg_w   <= reg_w_req && cond_ex;
      out_cond_ex <= cond_ex;
      if (cond_ex) begin
        if (flag_w[1]) flags[3:2] <= alu_nzcv[3:2];
        if (flag_w[0]) flags[1:0] <= alu_nzcv[1:0];
        if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
      end else begin
        if (squash_cnt != '1) squash_cnt <= squash_cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
